// File: rtl/crp16_writeback_unit_if.sv
// Producer handshakes, register-file write port and decode-side lookups of the
// CRP16 write-back unit, bundled so the decode/execute side connects in one place.
interface crp16_writeback_unit_if #(
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [2:0]               alu_sel;
  logic [15:0]              alu_val;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [2:0]               mem_sel;
  logic [15:0]              mem_val;
  logic                     wb_stall;
  logic                     write;
  logic [2:0]               write_sel;
  logic [15:0]              write_val;
  logic [7:0]               pending;
  logic [2:0]               fwd_sel;
  logic                     fwd_hit;
  logic [15:0]              fwd_val;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output alu_valid, alu_sel, alu_val, mem_valid, mem_sel, mem_val, wb_stall, fwd_sel,
    input  alu_ready, mem_ready, write, write_sel, write_val, pending, fwd_hit, fwd_val, count
  );

  modport slave (
    input  alu_valid, alu_sel, alu_val, mem_valid, mem_sel, mem_val, wb_stall, fwd_sel,
    output alu_ready, mem_ready, write, write_sel, write_val, pending, fwd_hit, fwd_val, count
  );
endinterface

// File: rtl/crp16_writeback_unit.sv
// CRP16 write-back front end: round-robin arbitration of ALU/load results into an
// in-order FIFO that retires one entry per cycle to the register file write port.
module crp16_writeback_unit #(
  parameter int DEPTH = 4
) (
  input logic                   clock,
  input logic                   reset,
  crp16_writeback_unit_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]    sel_q [DEPTH];
  logic [2:0]    sel_d [DEPTH];
  logic [15:0]   val_q [DEPTH];
  logic [15:0]   val_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_grant_q, last_grant_d;

  logic          full;
  logic          not_empty;
  logic          alu_acc;
  logic          mem_acc;
  logic          enq;
  logic          deq;
  logic [2:0]    in_sel;
  logic [15:0]   in_val;
  logic [7:0]    pend;
  logic          hit;
  logic [15:0]   hit_val;
  logic [PW-1:0] idx;

  // Readies look only at registered occupancy, so a retire never frees a slot in the same cycle.
  assign full         = (count_q == CW'(DEPTH));
  assign not_empty    = (count_q != '0);
  assign wb.alu_ready = !full && (!wb.mem_valid || last_grant_q);
  assign wb.mem_ready = !full && (!wb.alu_valid || !last_grant_q);
  assign alu_acc      = wb.alu_valid && wb.alu_ready;
  assign mem_acc      = wb.mem_valid && wb.mem_ready;
  assign enq          = alu_acc || mem_acc;
  assign in_sel       = mem_acc ? wb.mem_sel : wb.alu_sel;
  assign in_val       = mem_acc ? wb.mem_val : wb.alu_val;
  assign deq          = not_empty && !wb.wb_stall;

  assign wb.write     = deq;
  assign wb.write_sel = not_empty ? sel_q[rd_ptr_q] : 3'd0;
  assign wb.write_val = not_empty ? val_q[rd_ptr_q] : 16'd0;
  assign wb.count     = count_q;
  assign wb.pending   = pend;
  assign wb.fwd_hit   = hit;
  assign wb.fwd_val   = hit_val;

  always_comb begin
    sel_d        = sel_q;
    val_d        = val_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (enq) begin
      sel_d[wr_ptr_q] = in_sel;
      val_d[wr_ptr_q] = in_val;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      last_grant_d    = mem_acc;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the youngest matching entry is the one left in hit_val.
  always_comb begin
    pend    = '0;
    hit     = 1'b0;
    hit_val = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        pend[sel_q[idx]] = 1'b1;
        if (sel_q[idx] == wb.fwd_sel) begin
          hit     = 1'b1;
          hit_val = val_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i] <= '0;
        val_q[i] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      val_q        <= val_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: tb/tb_crp16_writeback_unit.sv
// Self-checking bench for crp16_writeback_unit: fixed vector table, randomized
// traffic against a queue-based reference model, and hand-written corner sequences.
module tb_crp16_writeback_unit;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  crp16_writeback_unit_if #(.DEPTH(DEPTH)) wb_if ();
  crp16_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb_if)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] val;
  } entry_t;

  typedef struct {
    logic          av;
    logic [2:0]    as;
    logic [15:0]   avl;
    logic          mv;
    logic [2:0]    ms;
    logic [15:0]   mvl;
    logic          stall;
    logic [2:0]    fs;
    logic          e_ar;
    logic          e_mr;
    logic          e_wr;
    logic [2:0]    e_ws;
    logic [15:0]   e_wv;
    logic [7:0]    e_pend;
    logic          e_hit;
    logic [15:0]   e_fv;
    logic [CW-1:0] e_cnt;
  } vec_t;

  entry_t      model_q[$];
  bit          model_lg;
  bit          last_alu_acc;
  bit          last_mem_acc;
  logic        exp_ar, exp_mr, exp_wr, exp_hit;
  logic [2:0]  exp_ws;
  logic [15:0] exp_wv, exp_fv;
  logic [7:0]  exp_pend;
  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: the queue is the FIFO, model_lg remembers who won last.
  task automatic predict();
    int  n;
    bit  is_full;
    n        = model_q.size();
    is_full  = (n == DEPTH);
    exp_ar   = !is_full && (!wb_if.mem_valid || model_lg);
    exp_mr   = !is_full && (!wb_if.alu_valid || !model_lg);
    exp_wr   = (n != 0) && !wb_if.wb_stall;
    exp_ws   = (n != 0) ? model_q[0].sel : 3'd0;
    exp_wv   = (n != 0) ? model_q[0].val : 16'd0;
    exp_pend = '0;
    foreach (model_q[i]) exp_pend[model_q[i].sel] = 1'b1;
    exp_hit  = 1'b0;
    exp_fv   = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (model_q[i].sel == wb_if.fwd_sel) begin
        exp_hit = 1'b1;
        exp_fv  = model_q[i].val;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [2:0] as, input logic [15:0] avl,
                               input logic mv, input logic [2:0] ms, input logic [15:0] mvl,
                               input logic stall, input logic [2:0] fs);
    wb_if.alu_valid = av;
    wb_if.alu_sel   = as;
    wb_if.alu_val   = avl;
    wb_if.mem_valid = mv;
    wb_if.mem_sel   = ms;
    wb_if.mem_val   = mvl;
    wb_if.wb_stall  = stall;
    wb_if.fwd_sel   = fs;
    @(negedge clock);
  endtask

  task automatic checkOutput();
    predict();
    check("alu_ready", 32'(wb_if.alu_ready), 32'(exp_ar));
    check("mem_ready", 32'(wb_if.mem_ready), 32'(exp_mr));
    check("write",     32'(wb_if.write),     32'(exp_wr));
    check("write_sel", 32'(wb_if.write_sel), 32'(exp_ws));
    check("write_val", 32'(wb_if.write_val), 32'(exp_wv));
    check("pending",   32'(wb_if.pending),   32'(exp_pend));
    check("fwd_hit",   32'(wb_if.fwd_hit),   32'(exp_hit));
    check("fwd_val",   32'(wb_if.fwd_val),   32'(exp_fv));
    check("count",     32'(wb_if.count),     32'(model_q.size()));
  endtask

  task automatic endCycle();
    entry_t e;
    predict();
    last_alu_acc = wb_if.alu_valid && exp_ar;
    last_mem_acc = wb_if.mem_valid && exp_mr;
    @(posedge clock);
    if (exp_wr) e = model_q.pop_front();
    if (last_alu_acc) begin
      model_q.push_back('{sel: wb_if.alu_sel, val: wb_if.alu_val});
      model_lg = 1'b0;
    end else if (last_mem_acc) begin
      model_q.push_back('{sel: wb_if.mem_sel, val: wb_if.mem_val});
      model_lg = 1'b1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        r_av, r_mv, r_stall;
    logic [2:0]  r_as, r_ms, r_fs;
    logic [15:0] r_avl, r_mvl;
    int          item;
    logic        av;

    model_lg     = 1'b0;
    last_alu_acc = 1'b0;
    last_mem_acc = 1'b0;
    r_av = 1'b0; r_mv = 1'b0; r_as = '0; r_ms = '0; r_avl = '0; r_mvl = '0;

    // Fields: inputs {av,as,avl, mv,ms,mvl, stall,fs}, then expected outputs.
    vecs[0]  = '{1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0,    1'b0,3'd3, 1'b1,1'b1,1'b0,3'd0,16'h0,    8'h00,1'b0,16'h0,    3'd0};
    vecs[1]  = '{1'b0,3'd0,16'h0,    1'b0,3'd0,16'h0,    1'b0,3'd3, 1'b1,1'b1,1'b1,3'd3,16'h1234, 8'h08,1'b1,16'h1234, 3'd1};
    vecs[2]  = '{1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'h5555, 1'b0,3'd1, 1'b0,1'b1,1'b0,3'd0,16'h0,    8'h00,1'b0,16'h0,    3'd0};
    vecs[3]  = '{1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'h5555, 1'b0,3'd1, 1'b1,1'b0,1'b1,3'd2,16'h5555, 8'h04,1'b0,16'h0,    3'd1};
    vecs[4]  = '{1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'h5555, 1'b0,3'd1, 1'b0,1'b1,1'b1,3'd1,16'hAAAA, 8'h02,1'b1,16'hAAAA, 3'd1};
    vecs[5]  = '{1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'h5555, 1'b0,3'd1, 1'b1,1'b0,1'b1,3'd2,16'h5555, 8'h04,1'b0,16'h0,    3'd1};
    vecs[6]  = '{1'b0,3'd0,16'h0,    1'b0,3'd0,16'h0,    1'b0,3'd1, 1'b1,1'b1,1'b1,3'd1,16'hAAAA, 8'h02,1'b1,16'hAAAA, 3'd1};
    vecs[7]  = '{1'b1,3'd5,16'h0001, 1'b0,3'd0,16'h0,    1'b1,3'd5, 1'b1,1'b1,1'b0,3'd0,16'h0,    8'h00,1'b0,16'h0,    3'd0};
    vecs[8]  = '{1'b1,3'd5,16'h0002, 1'b0,3'd0,16'h0,    1'b1,3'd5, 1'b1,1'b1,1'b0,3'd5,16'h0001, 8'h20,1'b1,16'h0001, 3'd1};
    vecs[9]  = '{1'b0,3'd0,16'h0,    1'b0,3'd0,16'h0,    1'b1,3'd5, 1'b1,1'b1,1'b0,3'd5,16'h0001, 8'h20,1'b1,16'h0002, 3'd2};
    vecs[10] = '{1'b0,3'd0,16'h0,    1'b0,3'd0,16'h0,    1'b1,3'd6, 1'b1,1'b1,1'b0,3'd5,16'h0001, 8'h20,1'b0,16'h0,    3'd2};
    vecs[11] = '{1'b0,3'd0,16'h0,    1'b0,3'd0,16'h0,    1'b0,3'd5, 1'b1,1'b1,1'b1,3'd5,16'h0001, 8'h20,1'b1,16'h0002, 3'd2};
    vecs[12] = '{1'b0,3'd0,16'h0,    1'b0,3'd0,16'h0,    1'b0,3'd5, 1'b1,1'b1,1'b1,3'd5,16'h0002, 8'h20,1'b1,16'h0002, 3'd1};
    vecs[13] = '{1'b0,3'd0,16'h0,    1'b0,3'd0,16'h0,    1'b0,3'd0, 1'b1,1'b1,1'b0,3'd0,16'h0,    8'h00,1'b0,16'h0,    3'd0};

    reset = 1'b1;
    wb_if.alu_valid = 1'b0; wb_if.alu_sel = '0; wb_if.alu_val = '0;
    wb_if.mem_valid = 1'b0; wb_if.mem_sel = '0; wb_if.mem_val = '0;
    wb_if.wb_stall  = 1'b0; wb_if.fwd_sel = '0;
    #2;
    check("reset count",   32'(wb_if.count),   32'd0);
    check("reset write",   32'(wb_if.write),   32'd0);
    check("reset pending", 32'(wb_if.pending), 32'd0);
    check("reset fwd_hit", 32'(wb_if.fwd_hit), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].av, vecs[i].as, vecs[i].avl, vecs[i].mv, vecs[i].ms, vecs[i].mvl,
                    vecs[i].stall, vecs[i].fs);
      check("tbl alu_ready", 32'(wb_if.alu_ready), 32'(vecs[i].e_ar));
      check("tbl mem_ready", 32'(wb_if.mem_ready), 32'(vecs[i].e_mr));
      check("tbl write",     32'(wb_if.write),     32'(vecs[i].e_wr));
      check("tbl write_sel", 32'(wb_if.write_sel), 32'(vecs[i].e_ws));
      check("tbl write_val", 32'(wb_if.write_val), 32'(vecs[i].e_wv));
      check("tbl pending",   32'(wb_if.pending),   32'(vecs[i].e_pend));
      check("tbl fwd_hit",   32'(wb_if.fwd_hit),   32'(vecs[i].e_hit));
      check("tbl fwd_val",   32'(wb_if.fwd_val),   32'(vecs[i].e_fv));
      check("tbl count",     32'(wb_if.count),     32'(vecs[i].e_cnt));
      endCycle();
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      // A producer left waiting keeps its sel/val until it is accepted.
      if (!(r_av && !last_alu_acc)) begin
        r_av  = ($urandom_range(0, 2) != 0);
        r_as  = 3'($urandom);
        r_avl = 16'($urandom);
      end
      if (!(r_mv && !last_mem_acc)) begin
        r_mv  = ($urandom_range(0, 2) != 0);
        r_ms  = 3'($urandom);
        r_mvl = 16'($urandom);
      end
      r_stall = ((c % 50) < 12) ? 1'b1 : ($urandom_range(0, 3) == 0);
      r_fs    = 3'($urandom);
      applyStimulus(r_av, r_as, r_avl, r_mv, r_ms, r_mvl, r_stall, r_fs);
      checkOutput();
      endCycle();
    end
    for (int c = 0; c < DEPTH + 1; c++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      checkOutput();
      endCycle();
    end

    $display("[TB] stall fill and drain");
    for (int k = 0; k < 10; k++) begin
      item = (k < 4) ? k : 4;
      av   = (k < 7);
      applyStimulus(av, 3'(item), 16'h0010 + 16'(item), 1'b0, 3'd0, 16'h0, (k < 5), 3'd0);
      checkOutput();
      if (k == 4) begin
        check("fill count",     32'(wb_if.count),     32'd4);
        check("fill alu_ready", 32'(wb_if.alu_ready), 32'd0);
        check("fill pending",   32'(wb_if.pending),   32'h0F);
      end
      if (k >= 5) begin
        check("drain write",     32'(wb_if.write),     32'd1);
        check("drain write_sel", 32'(wb_if.write_sel), 32'(k - 5));
        check("drain write_val", 32'(wb_if.write_val), 32'h10 + 32'(k - 5));
      end
      if (k == 5) check("full retire alu_ready", 32'(wb_if.alu_ready), 32'd0);
      if (k == 6) begin
        check("after retire alu_ready", 32'(wb_if.alu_ready), 32'd1);
        check("after retire count",     32'(wb_if.count),     32'd3);
      end
      if (k == 7) check("enq+retire count", 32'(wb_if.count), 32'd3);
      endCycle();
    end

    $display("[TB] asynchronous reset");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 3'(k + 1), 16'h0100 + 16'(k), 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
      checkOutput();
      endCycle();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd2);
    checkOutput();
    check("pre-reset count", 32'(wb_if.count), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("async count",     32'(wb_if.count),     32'd0);
    check("async write",     32'(wb_if.write),     32'd0);
    check("async pending",   32'(wb_if.pending),   32'd0);
    check("async fwd_hit",   32'(wb_if.fwd_hit),   32'd0);
    check("async write_sel", 32'(wb_if.write_sel), 32'd0);
    model_q.delete();
    model_lg     = 1'b0;
    last_alu_acc = 1'b0;
    last_mem_acc = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd6, 16'hCAFE, 1'b0, 3'd6);
    checkOutput();
    check("tie after reset mem_ready", 32'(wb_if.mem_ready), 32'd1);
    check("tie after reset alu_ready", 32'(wb_if.alu_ready), 32'd0);
    endCycle();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 3'd4, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd4);
      checkOutput();
      endCycle();
      wb_if.alu_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/crp16_writeback_unit.md
Name: crp16_writeback_unit

Overview:
- Write-side front end for the CRP16 8x16 register file. It drives the file's single write port (write, write_sel, write_val).
- Accepts results from two producers, the ALU and the load unit, over valid/ready handshakes, and arbitrates between them round-robin.
- Buffers accepted results in an in-order FIFO and retires at most one per cycle to the register file.
- Exposes per-register pending bits and a forwarding lookup so the decode stage can stall or bypass on queued results.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clock  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
alu_sel  in  3  ALU destination register
alu_val  in  16  ALU result data
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted this cycle when mem_valid && mem_ready
mem_sel  in  3  load destination register
mem_val  in  16  load result data
wb_stall  in  1  1 = hold the write port idle this cycle
write  out  1  register file write enable
write_sel  out  3  register file write index
write_val  out  16  register file write data
pending  out  8  bit r = 1 when any queued entry targets register r
fwd_sel  in  3  forwarding lookup index
fwd_hit  out  1  1 = a queued entry targets fwd_sel
fwd_val  out  16  data of the youngest queued entry targeting fwd_sel; 0 when no hit
count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- State: FIFO storage of DEPTH x {sel[2:0], val[15:0]}, rd_ptr, wr_ptr, count, and a 1-bit last_grant (0=ALU, 1=MEM).
- Reset values: FIFO empty, count=0, last_grant=0.
  - With the FIFO empty: write=0, write_sel=0, write_val=0, pending=0, fwd_hit=0, fwd_val=0.
  - Reset is asynchronous: outputs fall in the same cycle reset rises, and in-flight entries are discarded.
- Ready rules:
  - full = (count==DEPTH), taken from registered count only. There is no same-cycle pass-through of a dequeue.
  - alu_ready = !full && (!mem_valid || last_grant==1).
  - mem_ready = !full && (!alu_valid || last_grant==0).
  - Exactly one producer is granted per cycle. Ready must not depend combinationally on its own channel's valid; it may depend on the other channel's valid.
- Arbitration:
  - If only one channel is valid, that channel is granted.
  - If both are valid, the channel not granted last is granted. After reset, MEM wins the first tie.
  - last_grant updates only on an actual acceptance.
  - A non-granted valid producer must hold its sel/val stable until accepted; the unit does not check this.
- Enqueue: on a posedge with an accepted handshake, {sel,val} is written at wr_ptr, and wr_ptr increments, wrapping at DEPTH.
- Retire:
  - write = (count!=0) && !wb_stall.
  - write_sel and write_val are the head entry, driven combinationally from the FIFO. They are 0 when the FIFO is empty.
  - On a posedge with write=1, rd_ptr increments, wrapping at DEPTH.
  - The register file captures on the same edge, so the entry leaves the FIFO as the register updates.
- Latency: a result accepted at edge N appears on write during cycle N..N+1 and is committed to the register file at edge N+1, provided there is no stall and no older entries.
- Ordering: strict FIFO order. Two entries to the same register retire oldest first, so the last write wins.
- Simultaneous enqueue and retire on one edge: count unchanged, both pointers advance. This is legal when full: ready was 0, so no enqueue occurs.
- pending[r] = OR over valid entries of (sel==r). It is combinational from the registered FIFO and excludes the current-cycle incoming handshake.
- Forwarding:
  - fwd_hit and fwd_val come from a priority search from youngest (wr_ptr-1) to oldest (rd_ptr) over valid entries only.
  - The head entry is included even while being retired this cycle.
- Register 0 has no special case; it is written like any other.
- wb_stall held indefinitely: the FIFO fills, then both readies drop to 0 and the contents are preserved.

Test Plan:
1. Reset, then a single ALU result {sel=3, val=16'h1234} accepted at edge 1 -> write=1, write_sel=3, write_val=16'h1234 during cycle after edge 1; count back to 0 after edge 2; pending=0 after edge 2.
2. Both valid every cycle, with ALU={1,16'hAAAA} and MEM={2,16'h5555} -> grants in the order MEM, ALU, MEM, ALU; write_sel sequence 2,1,2,1 with one write per cycle.
3. wb_stall=1, ALU pushes 5 results {r0..r4, val=16'h0010+i} -> first 4 accepted, count=4, alu_ready=0 on the 5th, pending=8'h0F; release stall -> writes r0,r1,r2,r3 in order over 4 cycles, then the 5th accepted.
4. Stall with queued {r5,16'h0001} then {r5,16'h0002}, fwd_sel=5 -> fwd_hit=1, fwd_val=16'h0002; with fwd_sel=6 -> fwd_hit=0, fwd_val=0; unstall -> r5 written 0001 then 0002.
5. Full FIFO (DEPTH=4) with stall released and alu_valid=1 -> alu_ready=0 in the first retiring cycle, count 4->3, ready=1 next cycle; simultaneous enqueue/retire keeps count=3.
6. Reset asserted mid-cycle with count=3 -> write, pending, fwd_hit and count go to 0 immediately without a clock edge; after release, the first tie is granted to MEM.
